stopwatch_print_gen: RTL
========================

Name: stopwatch_print_gen

Overview:
- Downstream consumer of the stopwatch time outputs (data_hour, data_min, data_sec).
- Formats a snapshot as the 10-byte ASCII line "HH:MM:SS\r\n" and pushes it byte-by-byte into the UART TX FIFO write port.
- Prints on an explicit request pulse, or automatically on every seconds change when auto mode is enabled.
- Sits between the stopwatch top and the UART TX FIFO.

Parameters:
- MSG_LEN, 10, bytes per message: H1 H0 ':' M1 M0 ':' S1 S0 CR LF. Fixed; not meant to be overridden.
- CHAR_SEP, 8'h3A, separator byte (':').

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle print request (e.g. decoded UART command).
- auto_en  input  1  when 1, a change of data_sec triggers a print.
- data_sec  input  6  seconds, 0..63 accepted.
- data_min  input  6  minutes, 0..63 accepted.
- data_hour  input  5  hours, 0..31 accepted.
- fifo_full  input  1  TX FIFO full flag.
- fifo_wdata  output  8  byte presented to the FIFO.
- fifo_push  output  1  FIFO write enable.
- busy  output  1  high from LATCH through the last push.
- done  output  1  one-cycle pulse after the final byte (LF) is pushed.

Behaviour:
- Reset (async, active-high) forces the following; asserting it mid-message aborts the message and no further bytes are pushed:
  - state=IDLE, idx=0, pending=0, last_sec=0.
  - All latched digits = 0.
  - fifo_push=0, fifo_wdata=0, busy=0, done=0.
- Trigger, evaluated every clk: trig = start | (auto_en & (data_sec != last_sec)).
  - last_sec updates to data_sec every cycle, regardless of state.
- FSM states IDLE, LATCH, SEND, FIN:
  - IDLE: trig or pending -> LATCH; pending cleared.
  - LATCH (1 cycle): register hour/min/sec, convert each to two BCD digits, idx:=0, busy=1.
  - SEND: fifo_push = ~fifo_full. When push=1, idx increments. Push at idx=MSG_LEN-1 -> FIN.
  - FIN (1 cycle): done=1, busy=0 -> IDLE.
- Latency: trig sampled at edge N -> LATCH at N+1 -> first push at N+2 if the FIFO is not full.
  - Unstalled message: 10 push cycles; done in cycle N+12.
- fifo_push is combinational: (state==SEND) & ~fifo_full.
  - fifo_wdata is selected from the registered idx and latched digits. It holds stable while stalled and is 0 outside SEND.
- Full handling: while fifo_full=1, no push and idx holds. Resumes the cycle after full deasserts. No byte is lost or duplicated.
- Triggers during LATCH/SEND/FIN set pending (one-deep). Further triggers are merged into it.
  - The pending print uses values sampled at its own LATCH, not at trigger time.
- Digit conversion is combinational in LATCH: tens = v/10 (0..6 for 6-bit, 0..3 for 5-bit), ones = v - 10*tens.
  - Use a compare chain, not a generic divider.
  - ASCII byte = 8'h30 + digit.
  - Values above 59/23 print as-is (e.g. 63 -> "63"); no clamping.
- Byte order:
  - idx 0..4: H1, H0, ':', M1, M0.
  - idx 5..9: ':', S1, S0, 8'h0D, 8'h0A.
- start and trig arriving in the same cycle produce one print.

Decomposition:
- Shared package/header holds:
  - ASCII constants: ASCII_0=8'h30, ASCII_COLON=8'h3A, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
  - MSG_LEN.
  - FSM state encodings.
- One natural sub-module: bin2bcd_2dig. Converts 6-bit binary 0..63 to tens/ones nibbles, and is instantiated three times (hour zero-extended).

Test Plan:
- Reset, then hour=12, min=34, sec=56, start pulse, fifo_full=0 -> push sequence 31 32 3A 33 34 3A 35 36 0D 0A on 10 consecutive cycles from N+2; done pulses once; busy low afterwards.
- Same message with fifo_full held high from byte 3 for 5 cycles -> fifo_push=0 and wdata=3A held; after release bytes continue from 3A; exactly 10 pushes total.
- auto_en=1, sec steps 9->10 -> one message "00:00:10\r\n"; sec held constant 100 cycles -> no further messages.
- start pulses at N and again at N+4 while busy, min changes 0->1 at N+8 -> two messages: first shows min 00, second shows min 01; no third.
- Boundary values hour=31, min=63, sec=0 -> "31:63:00\r\n"; hour=0, min=0, sec=59 -> "00:00:59\r\n".
- Assert reset after byte 4 -> fifo_push drops immediately and busy=0; no done pulse; next start yields a complete 10-byte message.

Source files
------------

// File: rtl/stopwatch_print_gen_pkg.sv
// Shared constants, FSM encoding and digit record for the stopwatch print generator.
// The message is a fixed 10-byte ASCII line "HH:MM:SS\r\n".
package stopwatch_print_gen_pkg;

  localparam int MSG_LEN = 10;
  localparam int IDX_W   = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Snapshot digits held for the duration of one message
  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } digits_t;

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    return ASCII_0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/stopwatch_print_gen_bin2bcd.sv
// Two-digit binary to BCD conversion for values 0..63 using a compare chain.
// Values above 59 are converted as-is (63 -> tens 6, ones 3).
module bin2bcd_2dig
  import stopwatch_print_gen_pkg::*;
(
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [5:0] tens_x10;

  always_comb begin
    tens     = 4'd0;
    tens_x10 = 6'd0;
    if (bin >= 6'd60) begin
      tens     = 4'd6;
      tens_x10 = 6'd60;
    end else if (bin >= 6'd50) begin
      tens     = 4'd5;
      tens_x10 = 6'd50;
    end else if (bin >= 6'd40) begin
      tens     = 4'd4;
      tens_x10 = 6'd40;
    end else if (bin >= 6'd30) begin
      tens     = 4'd3;
      tens_x10 = 6'd30;
    end else if (bin >= 6'd20) begin
      tens     = 4'd2;
      tens_x10 = 6'd20;
    end else if (bin >= 6'd10) begin
      tens     = 4'd1;
      tens_x10 = 6'd10;
    end
    ones = 4'(bin - tens_x10);
  end

endmodule

// File: rtl/stopwatch_print_gen.sv
// Formats an hour/min/sec snapshot as "HH:MM:SS\r\n" and streams it into a TX FIFO.
// Prints on a start pulse or, in auto mode, on every change of the seconds value.
module stopwatch_print_gen
  import stopwatch_print_gen_pkg::*;
#(
  parameter logic [7:0] CHAR_SEP = ASCII_COLON
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       auto_en,
  input  logic [5:0] data_sec,
  input  logic [5:0] data_min,
  input  logic [4:0] data_hour,
  input  logic       fifo_full,
  output logic [7:0] fifo_wdata,
  output logic       fifo_push,
  output logic       busy,
  output logic       done
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  logic [5:0]       last_sec_q, last_sec_d;
  digits_t          digits_q, digits_d;
  digits_t          conv;
  logic             trig;

  bin2bcd_2dig u_hour (.bin({1'b0, data_hour}), .tens(conv.h1), .ones(conv.h0));
  bin2bcd_2dig u_min  (.bin(data_min),          .tens(conv.m1), .ones(conv.m0));
  bin2bcd_2dig u_sec  (.bin(data_sec),          .tens(conv.s1), .ones(conv.s0));

  assign trig = start | (auto_en & (data_sec != last_sec_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      last_sec_q <= '0;
      digits_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      last_sec_q <= last_sec_d;
      digits_q   <= digits_d;
    end
  end

  // A trigger seen while a message is in flight is folded into one pending print
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    last_sec_d = data_sec;
    digits_d   = digits_q;
    fifo_push  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig || pending_q) begin
          state_d   = ST_LATCH;
          pending_d = 1'b0;
        end
      end
      ST_LATCH: begin
        busy     = 1'b1;
        digits_d = conv;
        idx_d    = '0;
        state_d  = ST_SEND;
        if (trig) pending_d = 1'b1;
      end
      ST_SEND: begin
        busy      = 1'b1;
        fifo_push = ~fifo_full;
        if (trig) pending_d = 1'b1;
        if (!fifo_full) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
        if (trig) pending_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_wdata = 8'h00;
    if (state_q == ST_SEND) begin
      case (idx_q)
        4'd0:    fifo_wdata = digit_to_ascii(digits_q.h1);
        4'd1:    fifo_wdata = digit_to_ascii(digits_q.h0);
        4'd2:    fifo_wdata = CHAR_SEP;
        4'd3:    fifo_wdata = digit_to_ascii(digits_q.m1);
        4'd4:    fifo_wdata = digit_to_ascii(digits_q.m0);
        4'd5:    fifo_wdata = CHAR_SEP;
        4'd6:    fifo_wdata = digit_to_ascii(digits_q.s1);
        4'd7:    fifo_wdata = digit_to_ascii(digits_q.s0);
        4'd8:    fifo_wdata = ASCII_CR;
        4'd9:    fifo_wdata = ASCII_LF;
        default: fifo_wdata = 8'h00;
      endcase
    end
  end

endmodule
